sensor_ip_debounce_v3: RTL and testbench
========================================

// Module: sensor_ip_debounce_v3
// PURPOSE
//  Parametrised N-channel IR proximity sensor conditioner; replaces fixed 4+4 front/back filter.
//  Synchronises raw sensor pins, samples at a divided rate, debounces each channel by consecutive-sample count.
//  Emits clean levels plus per-channel rise/fall event pulses to the rover steering/avoidance logic.
// PARAMETERS
//  CHANNELS       8            number of sensor inputs (front[3:0] at [3:0], back[3:0] at [7:4])
//  CLK_HZ         100_000_000  clock frequency
//  SAMPLE_HZ      500          sampling rate; DIV = CLK_HZ/SAMPLE_HZ, must be >= 2
//  STABLE_SAMPLES 4            consecutive differing samples needed to change an output, range 1..15
//  ACTIVE_LOW     1            1: raw pin low = obstacle; input inverted after synchroniser
// PORTS
//  clock        in   1         system clock; single clock domain
//  reset        in   1         asynchronous, active-high reset
//  sens_in      in   CHANNELS  raw asynchronous sensor pins
//  sens_out     out  CHANNELS  debounced level, 1 = obstacle detected
//  rise_evt     out  CHANNELS  1-cycle pulse when sens_out bit goes 0->1
//  fall_evt     out  CHANNELS  1-cycle pulse when sens_out bit goes 1->0
//  any_active   out  1         OR of sens_out
//  sample_tick  out  1         1-cycle strobe at SAMPLE_HZ (debug)
//  irq          out  1         only with SENSOR_IP_IRQ_EN
//  irq_ack      in   1         only with SENSOR_IP_IRQ_EN
// BEHAVIOUR
//  Reset: sens_out, rise_evt, fall_evt, any_active, sample_tick, irq = 0; prescaler and all counters = 0;
//   synchroniser flops reset to the raw inactive level (1 if ACTIVE_LOW) so release of reset produces no event.
//  Sync: 2-flop synchroniser per channel, then polarity fix -> s[i].
//  Prescaler: counts 0..DIV-1, wraps to 0; sample_tick=1 in the cycle count==DIV-1.
//  Per channel, on sample_tick only:
//   s[i]==sens_out[i]            -> cnt[i]<=0
//   s[i]!=sens_out[i], cnt<S-1   -> cnt[i]<=cnt[i]+1
//   s[i]!=sens_out[i], cnt==S-1  -> sens_out[i]<=s[i], cnt[i]<=0, matching evt bit =1 next cycle only
//  Glitch shorter than S ticks: counter clears, no output change, no event.
//  Latency: input edge to sens_out <= 2 clocks + S*DIV clocks (+ up to DIV-1 phase).
//  Events registered with sens_out; multiple channels may pulse in the same cycle; rise and fall never both set on one bit.
//  Counter width = clog2(STABLE_SAMPLES)+1; prescaler width = clog2(DIV); no overflow possible by construction.
//  Reset asserted mid-debounce: all state cleared immediately, no pulses emitted.
//  any_active is combinational OR of registered sens_out (no extra latency).
// CONFIGURATION
//  SENSOR_IP_IRQ_EN defined: CHANNELS-wide sticky register; bit set on rise_evt or fall_evt,
//   cleared on irq_ack (all bits); set and ack in the same cycle -> set wins; irq = OR of sticky, registered.
//  Not defined: irq and irq_ack ports absent, no sticky register; all other behaviour identical.
// STRUCTURE
//  Shared package sensor_ip_pkg: clog2 function, default CLK_HZ/SAMPLE_HZ, channel index constants
//   (FRONT_BASE=0, BACK_BASE=4, CH_PER_SIDE=4).
//  Top holds synchroniser, prescaler, optional IRQ logic; generate loop of sub-module
//   sensor_debounce_ch (one channel: counter, output flop, rise/fall pulse) driven by s[i] and sample_tick.
// TESTING (bench params CLK_HZ=1000, SAMPLE_HZ=100 -> DIV=10, STABLE_SAMPLES=4, ACTIVE_LOW=1)
//  1 Reset with sens_in=8'hFF, release -> all outputs 0 for 200 clocks, no evt pulses; sample_tick every 10 clocks.
//  2 sens_in[0] 1->0 held -> sens_out=8'h01 within 2+40+9 clocks; rise_evt=8'h01 exactly one cycle; any_active=1.
//  3 sens_in[5] low for 25 clocks then high -> sens_out and events stay 0 (glitch rejected).
//  4 sens_in 8'hFF->8'h00 same cycle -> sens_out=8'hFF, rise_evt=8'hFF in one cycle; back to 8'hFF -> fall_evt=8'hFF.
//  5 Reset pulsed while channel 3 counter=2 -> sens_out stays 0, counter 0, no pulse after release.
//  6 IRQ build: rise on ch2 -> irq=1; irq_ack coinciding with fall on ch6 -> irq stays 1; next ack -> irq=0.

Source files
------------

// File: rtl/sensor_ip_pkg.sv
// Shared constants and helpers for the IR proximity sensor conditioner.
package sensor_ip_pkg;
  localparam int CLK_HZ_DEF    = 100_000_000;
  localparam int SAMPLE_HZ_DEF = 500;
  localparam int FRONT_BASE    = 0;
  localparam int BACK_BASE     = 4;
  localparam int CH_PER_SIDE   = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sensor_debounce_ch.sv
// One debounce channel: consecutive-differing-sample counter, level flop, edge pulses.
module sensor_debounce_ch
  import sensor_ip_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic s,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = clog2(STABLE_SAMPLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (s == level) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          level <= s;
          cnt   <= '0;
          rise  <= s;
          fall  <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/sensor_ip_debounce_v3.sv
// N-channel IR proximity sensor conditioner: sync, prescaled sampling, per-channel debounce.
// Optional sticky interrupt enabled by defining SENSOR_IP_IRQ_EN.
module sensor_ip_debounce_v3
  import sensor_ip_pkg::*;
#(
  parameter int CHANNELS       = 8,
  parameter int CLK_HZ         = CLK_HZ_DEF,
  parameter int SAMPLE_HZ      = SAMPLE_HZ_DEF,
  parameter int STABLE_SAMPLES = 4,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sens_in,
  output logic [CHANNELS-1:0] sens_out,
  output logic [CHANNELS-1:0] rise_evt,
  output logic [CHANNELS-1:0] fall_evt,
  output logic                any_active,
  output logic                sample_tick
`ifdef SENSOR_IP_IRQ_EN
  ,
  output logic                irq,
  input  logic                irq_ack
`endif
);
  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int PW  = clog2(DIV);
  // Sync flops idle at the raw inactive level so reset release looks like "no obstacle".
  localparam logic [CHANNELS-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CHANNELS-1:0] sync1, sync2, s;
  logic [PW-1:0]       pcnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= sens_in;
      sync2 <= sync1;
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  assign sample_tick = (pcnt == PW'(DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pcnt <= '0;
    else       pcnt <= sample_tick ? '0 : pcnt + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sensor_debounce_ch #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .s     (s[i]),
      .tick  (sample_tick),
      .level (sens_out[i]),
      .rise  (rise_evt[i]),
      .fall  (fall_evt[i])
    );
  end

  assign any_active = |sens_out;

`ifdef SENSOR_IP_IRQ_EN
  logic [CHANNELS-1:0] sticky, sticky_nxt;

  // New events land after the ack clear so a coincident event is never lost.
  assign sticky_nxt = (irq_ack ? '0 : sticky) | rise_evt | fall_evt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sticky <= '0;
      irq    <= 1'b0;
    end else begin
      sticky <= sticky_nxt;
      irq    <= |sticky_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_sensor_ip_debounce_v3.sv
// Self-checking bench for sensor_ip_debounce_v3: directed scenarios plus random pin activity vs a sample-history model.
module tb_sensor_ip_debounce_v3;
  localparam int CH  = 8;
  localparam int DIV = 10;
  localparam int S   = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] sens_in;
  logic [CH-1:0] sens_out, rise_evt, fall_evt;
  logic          any_active, sample_tick;
`ifdef SENSOR_IP_IRQ_EN
  logic          irq, irq_ack;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sensor_ip_debounce_v3 #(
    .CHANNELS(CH), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_SAMPLES(S), .ACTIVE_LOW(1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sens_in     (sens_in),
    .sens_out    (sens_out),
    .rise_evt    (rise_evt),
    .fall_evt    (fall_evt),
    .any_active  (any_active),
    .sample_tick (sample_tick)
`ifdef SENSOR_IP_IRQ_EN
    ,
    .irq         (irq),
    .irq_ack     (irq_ack)
`endif
  );

  // Reference: a level flips once the last S samples taken since its previous change all disagree with it.
  logic [CH-1:0] m_h1, m_h2, m_lvl, m_rise, m_fall;
  logic          m_tick;
  int            m_cyc;
  logic [15:0]   m_hist [CH];
  int            m_since [CH];

  always @(posedge clock or posedge reset) begin
    logic [CH-1:0] smp, lvl, r, f;
    logic [15:0]   h;
    int            since;
    bit            flip;
    if (reset) begin
      m_h1 <= '1; m_h2 <= '1; m_lvl <= '0; m_rise <= '0; m_fall <= '0;
      m_tick <= 1'b0; m_cyc <= 0;
      for (int i = 0; i < CH; i++) begin
        m_hist[i]  <= '0;
        m_since[i] <= 0;
      end
    end else begin
      smp = ~m_h2;
      lvl = m_lvl;
      r = '0;
      f = '0;
      if ((m_cyc % DIV) == DIV - 1) begin
        for (int i = 0; i < CH; i++) begin
          h     = {m_hist[i][14:0], smp[i]};
          since = m_since[i] + 1;
          flip  = (since >= S);
          for (int k = 0; k < S; k++)
            if (h[k] == lvl[i]) flip = 1'b0;
          if (flip) begin
            lvl[i] = smp[i];
            r[i]   = smp[i];
            f[i]   = ~smp[i];
            since  = 0;
          end
          m_hist[i]  <= h;
          m_since[i] <= since;
        end
      end
      m_lvl  <= lvl;
      m_rise <= r;
      m_fall <= f;
      m_h2   <= m_h1;
      m_h1   <= sens_in;
      m_cyc  <= m_cyc + 1;
      m_tick <= (((m_cyc + 1) % DIV) == DIV - 1);
    end
  end

`ifdef SENSOR_IP_IRQ_EN
  logic [CH-1:0] m_sticky;
  logic          m_irq;
  always @(posedge clock or posedge reset) begin
    logic [CH-1:0] nx;
    if (reset) begin
      m_sticky <= '0;
      m_irq    <= 1'b0;
    end else begin
      nx = (irq_ack ? '0 : m_sticky) | m_rise | m_fall;
      m_sticky <= nx;
      m_irq    <= |nx;
    end
  end
`endif

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk(32'(sens_out), 32'(m_lvl), "sens_out");
    chk(32'(rise_evt), 32'(m_rise), "rise_evt");
    chk(32'(fall_evt), 32'(m_fall), "fall_evt");
    chk(32'(any_active), 32'(|m_lvl), "any_active");
    chk(32'(sample_tick), 32'(m_tick), "sample_tick");
`ifdef SENSOR_IP_IRQ_EN
    chk(32'(irq), 32'(m_irq), "irq");
`endif
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      check_all();
    end
  endtask

  task automatic wait_lvl(input int ch, input logic v, input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      step(1);
      if (sens_out[ch] === v) hit = 1'b1;
    end
    chk(32'(hit), 32'd1, tag);
  endtask

  initial begin
    int  ticks, rises, clocks, evts;
    bit  hit;
    reset   = 1'b1;
    sens_in = 8'hFF;
`ifdef SENSOR_IP_IRQ_EN
    irq_ack = 1'b0;
`endif
    step(3);
    chk(32'(sens_out), 32'h0, "reset_sens_out");
    chk(32'(sample_tick), 32'h0, "reset_tick");

    // 1: idle after release, tick every DIV clocks
    reset = 1'b0;
    ticks = 0;
    evts  = 0;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if (sample_tick) ticks++;
      if (rise_evt != 0 || fall_evt != 0) evts++;
    end
    chk(32'(ticks), 32'd20, "t1_tick_count");
    chk(32'(evts), 32'd0, "t1_no_events");
    chk(32'(sens_out), 32'h0, "t1_idle_out");

    // 2: ch0 obstacle within latency bound, single rise pulse
    sens_in[0] = 1'b0;
    rises  = 0;
    clocks = 0;
    hit    = 1'b0;
    while (!hit && clocks < 60) begin
      step(1);
      clocks++;
      if (rise_evt[0]) rises++;
      if (sens_out[0]) hit = 1'b1;
    end
    chk(32'(hit && clocks <= 51), 32'd1, "t2_latency");
    chk(32'(sens_out), 32'h01, "t2_sens_out");
    chk(32'(any_active), 32'd1, "t2_any_active");
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (rise_evt[0]) rises++;
    end
    chk(32'(rises), 32'd1, "t2_one_rise");

    // 3: 25-clock glitch on ch5 rejected
    sens_in[5] = 1'b0;
    step(25);
    sens_in[5] = 1'b1;
    evts = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (rise_evt[5] || fall_evt[5]) evts++;
    end
    chk(32'(evts), 32'd0, "t3_no_glitch_evt");
    chk(32'(sens_out), 32'h01, "t3_sens_out");

    // 4: all channels move together
    sens_in[0] = 1'b1;
    wait_lvl(0, 1'b0, 80, "t4_ch0_clear");
    step(20);
    sens_in = 8'h00;
    hit = 1'b0;
    for (int k = 0; k < 80 && !hit; k++) begin
      step(1);
      if (sens_out != 0) hit = 1'b1;
    end
    chk(32'(sens_out), 32'hFF, "t4_all_on");
    chk(32'(rise_evt), 32'hFF, "t4_all_rise");
    sens_in = 8'hFF;
    hit = 1'b0;
    for (int k = 0; k < 80 && !hit; k++) begin
      step(1);
      if (sens_out != 8'hFF) hit = 1'b1;
    end
    chk(32'(sens_out), 32'h00, "t4_all_off");
    chk(32'(fall_evt), 32'hFF, "t4_all_fall");

    // 5: reset mid-debounce after two differing samples on ch3
    step(30);
    sens_in[3] = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      step(1);
      if (m_hist[3][2:0] == 3'b011) hit = 1'b1;
    end
    chk(32'(hit), 32'd1, "t5_reach_cnt2");
    reset      = 1'b1;
    sens_in[3] = 1'b1;
    step(2);
    chk(32'(sens_out), 32'h0, "t5_in_reset");
    reset = 1'b0;
    evts  = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (rise_evt != 0 || fall_evt != 0) evts++;
    end
    chk(32'(evts), 32'd0, "t5_no_pulse");
    sens_in[3] = 1'b0;
    wait_lvl(3, 1'b1, 80, "t5_full_debounce");
    sens_in[3] = 1'b1;
    wait_lvl(3, 1'b0, 80, "t5_release");

`ifdef SENSOR_IP_IRQ_EN
    // 6: sticky irq, set beats coincident ack
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    step(2);
    sens_in[2] = 1'b0;
    wait_lvl(2, 1'b1, 80, "t6_ch2_rise");
    step(2);
    chk(32'(irq), 32'd1, "t6_irq_set");
    sens_in[6] = 1'b0;
    wait_lvl(6, 1'b1, 80, "t6_ch6_rise");
    sens_in[6] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 80 && !hit; k++) begin
      step(1);
      if (m_fall[6]) hit = 1'b1;
    end
    chk(32'(hit), 32'd1, "t6_ch6_fall_seen");
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk(32'(irq), 32'd1, "t6_set_wins");
    step(2);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk(32'(irq), 32'd0, "t6_ack_clears");
    sens_in[2] = 1'b1;
    step(60);
`endif

    // Random pin activity with hold times around the debounce window
    repeat (40) begin
      sens_in = 8'($urandom);
      step($urandom_range(5, 60));
    end
    sens_in = 8'hFF;
    step(60);
    chk(32'(sens_out), 32'h0, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
